// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display, with dead time between digits.
// Define SEVSEG_DIM_EN to add the i_duty brightness input (PWM inside each digit's on-time).
module digit_scan_ctrl #(
    parameter int CLK_DIV   = 1024,
    parameter int BLANK_CYC = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [3:0] i_digit_mask,
`ifdef SEVSEG_DIM_EN
    input  logic [3:0] i_duty,
`endif
    output logic [1:0] o_sel,
    output logic [3:0] o_dig_en,
    output logic       o_frame_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [1:0]    sel_nxt;
    logic [3:0]    dig_en_nxt;
    logic          tick_nxt;
    logic [3:0]    lit_onehot;
    logic          lit_ok;

    function automatic logic [1:0] lowest_set(input logic [3:0] mask);
        lowest_set = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k]) lowest_set = 2'(k);
        end
    endfunction

    // Upward circular search from cur+1; k=4 wraps back onto cur itself.
    function automatic logic [1:0] next_set(input logic [1:0] cur, input logic [3:0] mask);
        next_set = cur;
        for (int k = 4; k >= 1; k--) begin
            if (mask[cur + 2'(k)]) next_set = cur + 2'(k);
        end
    endfunction

    assign cnt_inc = cnt + CW'(1);

`ifdef SEVSEG_DIM_EN
    logic [3:0] on_phase;
    assign on_phase = 4'(cnt_inc - CW'(BLANK_CYC));
    assign lit_ok   = (on_phase < i_duty);
`else
    assign lit_ok = 1'b1;
`endif

    // A digit whose mask bit drops mid-slot goes dark at once, but the slot keeps running.
    assign lit_onehot = lit_ok ? ((4'b0001 << o_sel) & i_digit_mask) : 4'b0000;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sel_nxt    = o_sel;
        dig_en_nxt = 4'b0000;
        tick_nxt   = 1'b0;
        if (!i_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_digit_mask != 4'b0000) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        sel_nxt   = lowest_set(i_digit_mask);
                    end
                end
                BLANK: begin
                    cnt_nxt = cnt_inc;
                    if (cnt == BLANK_LAST) begin
                        state_nxt  = ON;
                        dig_en_nxt = lit_onehot;
                    end
                end
                ON: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_nxt = '0;
                        if (i_digit_mask == 4'b0000) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = BLANK;
                            sel_nxt   = next_set(o_sel, i_digit_mask);
                            tick_nxt  = (sel_nxt <= o_sel);
                        end
                    end else begin
                        cnt_nxt    = cnt_inc;
                        dig_en_nxt = lit_onehot;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            o_sel        <= 2'd0;
            o_dig_en     <= 4'b0000;
            o_frame_tick <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            o_sel        <= sel_nxt;
            o_dig_en     <= dig_en_nxt;
            o_frame_tick <= tick_nxt;
        end
    end

endmodule
